// File: rtl/ode_arb_pkg.sv
// Shared types and default sizes for the result-RAM arbiter.
package ode_arb_pkg;

    localparam int ADDRESS_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF    = 64;
    localparam int FIFO_DEPTH_DEF    = 4;
    localparam int STAT_WIDTH        = 16;

    // CORE: core owns the read ports; DRAIN: flushing core writes before a
    // results send; SEND: the IO results sender owns the read ports.
    typedef enum logic [1:0] {
        ST_CORE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SEND  = 2'd2
    } arb_state_e;

    // One buffered core write at the default widths.
    typedef struct packed {
        logic [ADDRESS_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0]    data;
    } wr_entry_t;

endpackage

// File: rtl/ode_wr_fifo.sv
// Core write buffer: synchronous FIFO with an occupancy counter and a
// parallel address compare over all valid entries (read-after-write check).
module ode_wr_fifo
    import ode_arb_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH_DEF,
    parameter int  AW      = ADDRESS_WIDTH_DEF,
    parameter type entry_t = wr_entry_t
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    input  logic [AW-1:0] match_addr_a,
    input  logic [AW-1:0] match_addr_b,
    output logic          match
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] offs;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only taken when the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count decides full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // An entry is valid when its distance from the read pointer is below count.
    always_comb begin
        match = 1'b0;
        offs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ((CW'(offs) < count) &&
                ((mem[i].addr == match_addr_a) || (mem[i].addr == match_addr_b))) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ode_ram_arbiter.sv
// Result-RAM arbiter: merges IO and core writes onto the single write port
// and hands the two read ports to the core or the IO sender by phase.
// Optional build macro ARB_STATS_EN adds saturating stall/collision counters.
//
// Handshake: core writes transfer on core_wr_valid && core_wr_ready; core
// reads transfer on core_rd_valid && core_rd_ready. The core holds valid and
// its address/data stable until ready; ready never depends on a later cycle.
module ode_ram_arbiter
    import ode_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     io_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] io_wr_addr,
    input  logic [DATA_WIDTH-1:0]    io_wr_data,
    input  logic                     io_send_req,
    input  logic                     io_send_done,
    output logic                     io_send_grant,
    input  logic [ADDRESS_WIDTH-1:0] io_rd_addr_a,
    input  logic [ADDRESS_WIDTH-1:0] io_rd_addr_b,
    input  logic                     core_wr_valid,
    output logic                     core_wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] core_wr_addr,
    input  logic [DATA_WIDTH-1:0]    core_wr_data,
    input  logic                     core_rd_valid,
    output logic                     core_rd_ready,
    input  logic [ADDRESS_WIDTH-1:0] core_rd_addr_a,
    input  logic [ADDRESS_WIDTH-1:0] core_rd_addr_b,
    output logic                     core_rd_data_valid,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr_a,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr_b,
`ifdef ARB_STATS_EN
    output logic [STAT_WIDTH-1:0]    stall_cycles,
    output logic [STAT_WIDTH-1:0]    collision_cycles,
`endif
    output arb_state_e               dbg_state
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    arb_state_e state;
    arb_state_e state_next;
    entry_t     push_entry;
    entry_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_match;
    logic       fifo_push;
    logic       fifo_pop;
    logic       hazard;
    logic       rd_valid_q;

    // IO always wins the write port, so the FIFO head only drains on IO-idle cycles.
    assign fifo_pop      = !RST && !io_wr_en && !fifo_empty;
    assign core_wr_ready = !RST && (!fifo_full || fifo_pop);
    assign fifo_push     = core_wr_valid && core_wr_ready;
    assign push_entry    = '{addr: core_wr_addr, data: core_wr_data};

    ode_wr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .AW      (ADDRESS_WIDTH),
        .entry_t (entry_t)
    ) u_wr_fifo (
        .clk          (CLK),
        .rst          (RST),
        .push         (fifo_push),
        .push_entry   (push_entry),
        .pop          (fifo_pop),
        .head         (head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .match_addr_a (core_rd_addr_a),
        .match_addr_b (core_rd_addr_b),
        .match        (fifo_match)
    );

    // Write-port mux: IO pass-through first, else the FIFO head; silent in reset.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (!RST) begin
            if (io_wr_en) begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = io_wr_addr;
                ram_wr_data = io_wr_data;
            end else if (!fifo_empty) begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = head.addr;
                ram_wr_data = head.data;
            end
        end
    end

    // A read must not overtake a pending write or the write landing this cycle.
    assign hazard = fifo_match ||
                    (ram_wr_en && ((ram_wr_addr == core_rd_addr_a) ||
                                   (ram_wr_addr == core_rd_addr_b)));
    assign core_rd_ready = !RST && (state == ST_CORE) && core_rd_valid && !hazard;

    // Read-port mux: IO addresses in SEND, otherwise the core's (zero when idle).
    always_comb begin
        ram_rd_addr_a = '0;
        ram_rd_addr_b = '0;
        if (!RST) begin
            if (state == ST_SEND) begin
                ram_rd_addr_a = io_rd_addr_a;
                ram_rd_addr_b = io_rd_addr_b;
            end else if (core_rd_valid) begin
                ram_rd_addr_a = core_rd_addr_a;
                ram_rd_addr_b = core_rd_addr_b;
            end
        end
    end

    assign io_send_grant      = !RST && (state == ST_SEND);
    assign core_rd_data_valid = !RST && rd_valid_q;
    assign dbg_state          = state;

    // Phase next-state: a send request always spends at least one cycle in DRAIN.
    always_comb begin
        state_next = state;
        case (state)
            ST_CORE:  if (io_send_req)  state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)   state_next = ST_SEND;
            ST_SEND:  if (io_send_done) state_next = ST_CORE;
            default:                    state_next = ST_CORE;
        endcase
    end

    // Phase register and the one-cycle read-latency tag for core read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_CORE;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            rd_valid_q <= core_rd_ready;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating counters of core write stalls and IO-deferred FIFO pops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles     <= '0;
            collision_cycles <= '0;
        end else begin
            if (core_wr_valid && !core_wr_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (io_wr_en && !fifo_empty && (collision_cycles != '1))
                collision_cycles <= collision_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ode_ram_arbiter.sv
// Directed self-checking bench for ode_ram_arbiter (default FIFO_DEPTH=4).
module tb_ode_ram_arbiter;
    import ode_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 64;

    logic          CLK;
    logic          RST;
    logic          io_wr_en;
    logic [AW-1:0] io_wr_addr;
    logic [DW-1:0] io_wr_data;
    logic          io_send_req;
    logic          io_send_done;
    logic          io_send_grant;
    logic [AW-1:0] io_rd_addr_a;
    logic [AW-1:0] io_rd_addr_b;
    logic          core_wr_valid;
    logic          core_wr_ready;
    logic [AW-1:0] core_wr_addr;
    logic [DW-1:0] core_wr_data;
    logic          core_rd_valid;
    logic          core_rd_ready;
    logic [AW-1:0] core_rd_addr_a;
    logic [AW-1:0] core_rd_addr_b;
    logic          core_rd_data_valid;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr_a;
    logic [AW-1:0] ram_rd_addr_b;
    arb_state_e    dbg_state;
`ifdef ARB_STATS_EN
    logic [15:0]   stall_cycles;
    logic [15:0]   collision_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_e;
    int j;

    ode_ram_arbiter dut (
        .CLK                (CLK),
        .RST                (RST),
        .io_wr_en           (io_wr_en),
        .io_wr_addr         (io_wr_addr),
        .io_wr_data         (io_wr_data),
        .io_send_req        (io_send_req),
        .io_send_done       (io_send_done),
        .io_send_grant      (io_send_grant),
        .io_rd_addr_a       (io_rd_addr_a),
        .io_rd_addr_b       (io_rd_addr_b),
        .core_wr_valid      (core_wr_valid),
        .core_wr_ready      (core_wr_ready),
        .core_wr_addr       (core_wr_addr),
        .core_wr_data       (core_wr_data),
        .core_rd_valid      (core_rd_valid),
        .core_rd_ready      (core_rd_ready),
        .core_rd_addr_a     (core_rd_addr_a),
        .core_rd_addr_b     (core_rd_addr_b),
        .core_rd_data_valid (core_rd_data_valid),
        .ram_wr_en          (ram_wr_en),
        .ram_wr_addr        (ram_wr_addr),
        .ram_wr_data        (ram_wr_data),
        .ram_rd_addr_a      (ram_rd_addr_a),
        .ram_rd_addr_b      (ram_rd_addr_b),
`ifdef ARB_STATS_EN
        .stall_cycles       (stall_cycles),
        .collision_cycles   (collision_cycles),
`endif
        .dbg_state          (dbg_state)
    );

    // Clock and reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 2-3 units after the edge.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        io_wr_en = 0; io_wr_addr = '0; io_wr_data = '0;
        io_send_req = 0; io_send_done = 0;
        io_rd_addr_a = '0; io_rd_addr_b = '0;
        core_wr_valid = 0; core_wr_addr = '0; core_wr_data = '0;
        core_rd_valid = 0; core_rd_addr_a = '0; core_rd_addr_b = '0;
    endtask

    initial begin
        // ---- Reset: outputs silent even with live inputs ----
        idle_inputs();
        RST = 1;
        io_wr_en = 1; io_wr_addr = 13'h1FF; io_wr_data = 64'h55;
        core_rd_valid = 1; core_rd_addr_a = 13'h7; core_wr_valid = 1;
        cyc();
        #1;
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_ram_wr_addr", ram_wr_addr, 0);
        chk("rst_wr_ready", core_wr_ready, 0);
        chk("rst_rd_ready", core_rd_ready, 0);
        chk("rst_rd_addr_a", ram_rd_addr_a, 0);
        chk("rst_grant", io_send_grant, 0);
        chk("rst_state", dbg_state, ST_CORE);
        cyc();
        RST = 0;
        idle_inputs();
        #1;
        chk("post_rst_wr_ready", core_wr_ready, 1);
        chk("post_rst_ram_wr_en", ram_wr_en, 0);
        chk("post_rst_rd_dv", core_rd_data_valid, 0);
        cyc();

        // ---- Core writes 0x10..0x13 back-to-back, no IO ----
        for (int k = 0; k < 4; k++) begin
            core_wr_valid = 1; core_wr_addr = AW'(13'h10 + k); core_wr_data = 64'hA0 + 64'(k);
            #1;
            chk("t2_wr_ready", core_wr_ready, 1);
            if (k == 0) begin
                chk("t2_ram_idle", ram_wr_en, 0);
            end else begin
                chk("t2_ram_en", ram_wr_en, 1);
                chk("t2_ram_addr", ram_wr_addr, 64'h10 + 64'(k - 1));
                chk("t2_ram_data", ram_wr_data, 64'hA0 + 64'(k - 1));
            end
            cyc();
        end
        core_wr_valid = 0;
        #1;
        chk("t2_last_en", ram_wr_en, 1);
        chk("t2_last_addr", ram_wr_addr, 13'h13);
        chk("t2_last_data", ram_wr_data, 64'hA3);
        cyc();
        #1;
        chk("t2_drained", ram_wr_en, 0);
        cyc();

        // ---- IO holds the write port 6 cycles while the core pushes 5 ----
        j = 0;
        for (int c = 0; c < 12; c++) begin
            io_wr_en = (c < 6); io_wr_addr = AW'(13'h100 + c); io_wr_data = 64'h1000 + 64'(c);
            core_wr_valid = (j < 5); core_wr_addr = AW'(13'h200 + j); core_wr_data = 64'h2000 + 64'(j);
            #1;
            if (c < 6) begin
                chk("t3_io_en", ram_wr_en, 1);
                chk("t3_io_addr", ram_wr_addr, 64'h100 + 64'(c));
                chk("t3_io_data", ram_wr_data, 64'h1000 + 64'(c));
            end else if (c < 11) begin
                chk("t3_core_en", ram_wr_en, 1);
                chk("t3_core_addr", ram_wr_addr, 64'h200 + 64'(c - 6));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL t3_sb_empty: observed write %0h expected none", ram_wr_addr);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("t3_sb_addr", ram_wr_addr, exp_e[AW+DW-1:DW]);
                    chk("t3_sb_data", ram_wr_data, exp_e[DW-1:0]);
                end
            end else begin
                chk("t3_idle", ram_wr_en, 0);
            end
            if (j < 5) chk("t3_wr_ready", core_wr_ready, (c < 4 || c >= 6) ? 1 : 0);
            if (core_wr_valid && core_wr_ready) begin
                exp_q.push_back({core_wr_addr, core_wr_data});
                j++;
            end
            cyc();
        end
        chk("t3_push_count", j, 5);
        chk("t3_sb_left", exp_q.size(), 0);
        idle_inputs();

        // ---- Read-after-write hazard on 0x20 ----
        io_wr_en = 1; io_wr_addr = 13'h300; io_wr_data = 64'h3;
        core_wr_valid = 1; core_wr_addr = 13'h20; core_wr_data = 64'hBEEF;
        #1;
        chk("t4_io_wins", ram_wr_addr, 13'h300);
        cyc();
        core_wr_valid = 0; io_wr_addr = 13'h301;
        core_rd_valid = 1; core_rd_addr_a = 13'h20; core_rd_addr_b = 13'h21;
        #1;
        chk("t4_fifo_hazard", core_rd_ready, 0);
        chk("t4_rd_addr_a", ram_rd_addr_a, 13'h20);
        chk("t4_rd_addr_b", ram_rd_addr_b, 13'h21);
        cyc();
        io_wr_en = 0;
        #1;
        chk("t4_pop_addr", ram_wr_addr, 13'h20);
        chk("t4_pop_data", ram_wr_data, 64'hBEEF);
        chk("t4_wr_hazard", core_rd_ready, 0);
        cyc();
        #1;
        chk("t4_no_write", ram_wr_en, 0);
        chk("t4_accept", core_rd_ready, 1);
        chk("t4_dv_early", core_rd_data_valid, 0);
        cyc();
        core_rd_addr_a = 13'h30; core_rd_addr_b = 13'h21;
        io_wr_en = 1; io_wr_addr = 13'h21;
        #1;
        chk("t4_dv", core_rd_data_valid, 1);
        chk("t4_io_hazard_b", core_rd_ready, 0);
        cyc();
        idle_inputs();
        #1;
        chk("t4_dv_drop", core_rd_data_valid, 0);
        chk("t4_rd_addr_idle", ram_rd_addr_a, 0);
        cyc();

        // ---- Send request with 3 buffered writes ----
        for (int s = 0; s < 3; s++) begin
            io_wr_en = 1; io_wr_addr = AW'(13'h400 + s); io_wr_data = 64'(s);
            core_wr_valid = 1; core_wr_addr = AW'(13'h40 + s); core_wr_data = 64'h4000 + 64'(s);
            cyc();
        end
        idle_inputs();
        io_send_req = 1;
        #1;
        chk("t5_req_state", dbg_state, ST_CORE);
        chk("t5_req_pop", ram_wr_addr, 13'h40);
        chk("t5_req_grant", io_send_grant, 0);
        cyc();
        io_send_req = 0;
        core_rd_valid = 1; core_rd_addr_a = 13'h50; core_rd_addr_b = 13'h51;
        for (int d = 0; d < 3; d++) begin
            #1;
            chk("t5_drain_state", dbg_state, ST_DRAIN);
            chk("t5_drain_grant", io_send_grant, 0);
            chk("t5_drain_rd_ready", core_rd_ready, 0);
            chk("t5_drain_wr_en", ram_wr_en, (d < 2) ? 1 : 0);
            if (d < 2) chk("t5_drain_addr", ram_wr_addr, 64'h41 + 64'(d));
            cyc();
        end
        io_rd_addr_a = 13'h111; io_rd_addr_b = 13'h122; io_send_done = 1;
        #1;
        chk("t5_send_state", dbg_state, ST_SEND);
        chk("t5_send_grant", io_send_grant, 1);
        chk("t5_send_rd_a", ram_rd_addr_a, 13'h111);
        chk("t5_send_rd_b", ram_rd_addr_b, 13'h122);
        chk("t5_send_rd_ready", core_rd_ready, 0);
        cyc();
        io_send_done = 0;
        #1;
        chk("t5_back_state", dbg_state, ST_CORE);
        chk("t5_back_grant", io_send_grant, 0);
        chk("t5_back_rd_ready", core_rd_ready, 1);
        chk("t5_back_rd_a", ram_rd_addr_a, 13'h50);
        cyc();
        idle_inputs();

        // ---- Send request with the FIFO already empty: one DRAIN cycle ----
        io_send_req = 1;
        #1;
        chk("t5e_state0", dbg_state, ST_CORE);
        cyc();
        io_send_req = 0;
        #1;
        chk("t5e_drain", dbg_state, ST_DRAIN);
        chk("t5e_drain_grant", io_send_grant, 0);
        cyc();
        #1;
        chk("t5e_send", dbg_state, ST_SEND);
        chk("t5e_grant", io_send_grant, 1);
        cyc();

        // ---- Reset in SEND with 2 pending core writes ----
        for (int r = 0; r < 2; r++) begin
            io_wr_en = 1; io_wr_addr = AW'(13'h500 + r);
            core_wr_valid = 1; core_wr_addr = AW'(13'h60 + r); core_wr_data = 64'h6000 + 64'(r);
            #1;
            chk("t6_push_ready", core_wr_ready, 1);
            cyc();
        end
        RST = 1; core_rd_valid = 1; core_rd_addr_a = 13'h70;
        #1;
        chk("t6_rst_wr_en", ram_wr_en, 0);
        chk("t6_rst_wr_addr", ram_wr_addr, 0);
        chk("t6_rst_wr_ready", core_wr_ready, 0);
        chk("t6_rst_rd_ready", core_rd_ready, 0);
        chk("t6_rst_rd_a", ram_rd_addr_a, 0);
        chk("t6_rst_grant", io_send_grant, 0);
        chk("t6_rst_dv", core_rd_data_valid, 0);
        cyc();
        RST = 0;
        idle_inputs();
        for (int r = 0; r < 3; r++) begin
            #1;
            chk("t6_state", dbg_state, ST_CORE);
            chk("t6_grant", io_send_grant, 0);
            chk("t6_no_stale", ram_wr_en, 0);
            chk("t6_wr_ready", core_wr_ready, 1);
            cyc();
        end

`ifdef ARB_STATS_EN
        // ---- Statistics counters ----
        RST = 1;
        cyc();
        RST = 0;
        for (int i = 0; i < 14; i++) begin
            io_wr_en = 1; io_wr_addr = 13'h600;
            core_wr_valid = 1; core_wr_addr = AW'(13'h700 + i);
            cyc();
        end
        idle_inputs();
        #1;
        chk("st_stall10", stall_cycles, 10);
        chk("st_collision13", collision_cycles, 13);
        io_wr_en = 1; core_wr_valid = 1; core_wr_addr = 13'h7FF;
        repeat (70000) cyc();
        #1;
        chk("st_stall_sat", stall_cycles, 16'hFFFF);
        chk("st_coll_sat", collision_cycles, 16'hFFFF);
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
